// File: rtl/fp_vec3_len_sq_folded.sv
// Folded squared-length stage: x^2+y^2+z^2 over three cycles with one shared
// multiplier, feeding a_in of the inverse-sqrt stage of the normalise path.
//
// Ports:
//   clk_in      clock, all state on rising edge
//   rst_in      asynchronous active-low reset
//   vec_in      {z,y,x}, x in bits [WIDTH-1:0], signed fixed point
//   valid_in    vec_in valid
//   ready_out   block can accept vec_in this cycle
//   len_sq_out  saturated x^2+y^2+z^2, same fixed-point format
//   vec_out     copy of the accepted vector
//   ovf_out     len_sq_out was saturated
//   zero_out    len_sq_out == 0
//   valid_out   outputs valid
//   ready_in    downstream ready
module fp_vec3_len_sq_folded #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [3*WIDTH-1:0]   vec_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic [WIDTH-1:0]     len_sq_out,
    output logic [3*WIDTH-1:0]   vec_out,
    output logic                 ovf_out,
    output logic                 zero_out,
    output logic                 valid_out,
    input  logic                 ready_in
);

    localparam int PW = 2 * WIDTH;
    localparam int AW = 2 * WIDTH + 2;

    // Largest positive WIDTH-bit value, zero-extended to accumulator width.
    localparam logic [AW-1:0] SAT_LIM =
        {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQ_X,
        S_SQ_Y,
        S_SQ_Z,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [3*WIDTH-1:0]     r_vec;
    logic [AW-1:0]          r_acc;
    logic [WIDTH-1:0]       r_len;
    logic                   r_ovf;
    logic                   r_zero;

    logic                   w_accept;
    logic                   w_sq_step;
    logic signed [WIDTH-1:0] w_opnd;
    logic signed [PW-1:0]   w_opnd_ext;
    logic signed [PW-1:0]   w_prod_full;
    logic signed [PW-1:0]   w_prod_sh;
    logic [AW-1:0]          w_acc_next;
    logic                   w_sat;
    logic [WIDTH-1:0]       w_len_next;

    // Ready in DONE is combinational from ready_in so a result can be
    // handed off and the next vector taken on the same edge.
    assign ready_out = (r_state == S_IDLE)
                    || ((r_state == S_DONE) && ready_in);
    assign valid_out = (r_state == S_DONE);
    assign w_accept  = valid_in && ready_out;
    assign w_sq_step = (r_state == S_SQ_X)
                    || (r_state == S_SQ_Y)
                    || (r_state == S_SQ_Z);

    // Shared multiplier operand: the component being squared this cycle.
    always_comb begin
        w_opnd = '0;
        unique case (r_state)
            S_SQ_X:  w_opnd = r_vec[WIDTH-1:0];
            S_SQ_Y:  w_opnd = r_vec[2*WIDTH-1:WIDTH];
            S_SQ_Z:  w_opnd = r_vec[3*WIDTH-1:2*WIDTH];
            default: w_opnd = '0;
        endcase
    end

    // Full-width signed square; even -2^(WIDTH-1) squared fits in PW bits.
    assign w_opnd_ext  = {{WIDTH{w_opnd[WIDTH-1]}}, w_opnd};
    assign w_prod_full = w_opnd_ext * w_opnd_ext;
    assign w_prod_sh   = w_prod_full >>> FRAC;

    // A square is never negative, so zero-extension into the
    // unsigned accumulator is exact.
    assign w_acc_next  = r_acc + {2'b00, w_prod_sh};

    assign w_sat       = (w_acc_next > SAT_LIM);
    assign w_len_next  = w_sat ? SAT_LIM[WIDTH-1:0]
                               : w_acc_next[WIDTH-1:0];

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_SQ_X;
                end
            end
            S_SQ_X: w_next = S_SQ_Y;
            S_SQ_Y: w_next = S_SQ_Z;
            S_SQ_Z: w_next = S_DONE;
            S_DONE: begin
                if (w_accept) begin
                    w_next = S_SQ_X;
                end else if (ready_in) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_vec  <= '0;
            r_acc  <= '0;
            r_len  <= '0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_vec  <= vec_in;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
        end else if (w_sq_step) begin
            r_acc <= w_acc_next;
            // Result registers only move on the last square, so no
            // partial sum ever reaches the outputs.
            if (r_state == S_SQ_Z) begin
                r_len  <= w_len_next;
                r_ovf  <= w_sat;
                r_zero <= (w_len_next == '0);
            end
        end
    end

    assign len_sq_out = r_len;
    assign vec_out    = r_vec;
    assign ovf_out    = r_ovf;
    assign zero_out   = r_zero;

endmodule

// File: doc/fp_vec3_len_sq_folded.md
Name: fp_vec3_len_sq_folded

Overview:
- Folded upstream stage for fp_inv_sqrt_folded in the ray-marcher normalisation path.
- Accepts a 3-component fixed-point vector and computes x²+y²+z² with one shared multiplier over three cycles.
- Presents the squared length (to drive a_in of the inverse-sqrt stage) together with the original vector, for the downstream scale step.
- Valid/ready handshake on both sides.

Parameters:
WIDTH, 32, total bits of one fixed-point value (matches fp type)
FRAC, 16, fractional bits (two's complement, Q16.16 at defaults)

Ports:
clk_in  input  1  clock, all state on rising edge
rst_in  input  1  reset, asynchronous, active-low
vec_in  input  3*WIDTH  {z,y,x}, x in bits [WIDTH-1:0]
valid_in  input  1  vec_in valid
ready_out  output  1  block can accept vec_in this cycle
len_sq_out  output  WIDTH  x²+y²+z², same fixed-point format, non-negative
vec_out  output  3*WIDTH  copy of accepted vec_in
ovf_out  output  1  result saturated
zero_out  output  1  len_sq_out == 0 (downstream must not invert)
valid_out  output  1  outputs valid
ready_in  input  1  downstream ready (driven by fp_inv_sqrt_folded ready_out)

Behaviour:
- States: IDLE, SQ_X, SQ_Y, SQ_Z, DONE. Reset state is IDLE.
- While rst_in is low, outputs are: valid_out=0, ready_out=1, len_sq_out=0, vec_out=0, ovf_out=0, zero_out=0. Accumulator is 0.
- ready_out = (state==IDLE) || (state==DONE && ready_in). This is a combinational path from ready_in; it is intentional.
- Accept: valid_in && ready_out at edge k. At that edge:
  - latch vec_in into vec_out;
  - clear the accumulator and sticky overflow;
  - go to SQ_X.
- Square step, one per state:
  - Product p = c*c computed at 2*WIDTH bits signed, then arithmetic-shifted right by FRAC (truncation toward −inf; p ≥ 0, so this is floor).
  - Product is added into an unsigned accumulator of 2*WIDTH+2 bits.
  - SQ_X uses x at edge k+1, SQ_Y uses y at edge k+2, SQ_Z uses z at edge k+3.
  - Transitions: SQ_X→SQ_Y→SQ_Z→DONE.
- Output is formed at edge k+3:
  - If accumulator > 2^(WIDTH-1)−1: len_sq_out = 2^(WIDTH-1)−1 and ovf_out=1.
  - Else: len_sq_out = accumulator[WIDTH-1:0] and ovf_out=0.
  - zero_out = (len_sq_out==0).
  - valid_out rises after edge k+3, so latency is 3 cycles from the accept edge to valid_out high.
- In DONE, all outputs are held stable until valid_out && ready_in at an edge:
  - If valid_in is also high, the new vector is accepted that same edge and the state goes to SQ_X; valid_out drops.
  - Else the state goes to IDLE and valid_out drops.
  - Sustained throughput: one result per 4 cycles.
- valid_out is low in all states other than DONE. len_sq_out, vec_out and flags keep their last values in IDLE.
- valid_in while busy (SQ_*) is ignored: ready_out=0, and upstream must hold its data.
- Inputs are sampled only at the accept edge; vec_in changes during SQ_* have no effect.
- Reset asserted mid-operation (any state) aborts immediately to the reset values. No partial result is ever presented.
- Most negative input (−2^(WIDTH-1)) squares correctly in the 2*WIDTH product and saturates. No other overflow path exists.

Test Plan:
- x=1.0, y=2.0, z=2.0 (32'h0001_0000, 32'h0002_0000, 32'h0002_0000), ready_in=1 → valid_out 3 cycles after accept, len_sq_out=32'h0009_0000, ovf=0, zero=0, vec_out equals input.
- (−0.5, 0.5, 0.5) = (32'hFFFF_8000, 32'h0000_8000, 32'h0000_8000) → len_sq_out=32'h0000_C000 (0.75).
- (200.0, 0, 0) = 32'h00C8_0000 → sum 40000 > 32767.99998, so len_sq_out=32'h7FFF_FFFF, ovf_out=1. Also run (−32768.0, 0, 0) → same saturated result.
- (32'h0000_0001, 0, 0) → square truncates to 0, so len_sq_out=0, zero_out=1.
- Backpressure: ready_in=0 for 10 cycles after valid_out rises → all outputs stable, ready_out=0. Raise ready_in together with a new valid_in → handshake and new accept on the same edge, next result 3 cycles later.
- Streaming: valid_in and ready_in held high, 5 vectors → exactly one result every 4 cycles, in order. Pull rst_in low during SQ_Y → valid_out=0, ready_out=1 asynchronously; after release the next vector computes correctly.
